// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator
//
// Tail stage for the 4x4 array multiplier. It takes a batch of LEN unsigned
// products over a valid/ready input and adds them into a wide accumulator.
// It then presents one registered sum over a valid/ready output.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a batch (only looked at in IDLE)
//   len        products per batch, 0 means 2**LEN_W; latched with start
//   clear      synchronous abort to IDLE, overrides everything else
//   in_valid   product available
//   in_ready   block accepts a product this cycle (high only in ACCUM)
//   in_prod    unsigned product from the multiplier
//   out_valid  result held and valid (high only in DONE)
//   out_ready  consumer takes the result
//   out_sum    accumulated sum modulo 2**ACC_W
//   out_ovf    sticky carry-out seen during the batch
//   busy       high in ACCUM or DONE
//   count      products accepted so far in the current batch
//
// All outputs come from registers or from a state decode. No input reaches
// an output combinationally.
module mult_product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy,
    output logic [LEN_W:0]    count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [LEN_W:0]   target_reg;
    logic [LEN_W:0]   count_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;
    logic [ACC_W-1:0] out_sum_reg;
    logic             out_ovf_reg;

    logic             accept;
    logic [ACC_W:0]   sum_next;
    logic             ovf_next;
    logic [LEN_W:0]   count_next;
    logic [LEN_W:0]   target_next;

    assign accept = in_valid && (state_reg == ACCUM);

    // The extra top bit of the sum is the carry out of the accumulator.
    assign sum_next   = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign ovf_next   = ovf_reg | sum_next[ACC_W];
    assign count_next = count_reg + {{LEN_W{1'b0}}, 1'b1};

    // A length of zero selects the full 2**LEN_W batch. That is why target
    // and count carry one more bit than len.
    assign target_next = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            target_reg  <= '0;
            count_reg   <= '0;
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            out_sum_reg <= '0;
            out_ovf_reg <= 1'b0;
        end else if (clear) begin
            // The result registers keep their last value. out_valid is
            // decoded from state, so they are no longer presented as valid.
            state_reg <= IDLE;
            count_reg <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        target_reg <= target_next;
                        count_reg  <= '0;
                        acc_reg    <= '0;
                        ovf_reg    <= 1'b0;
                        state_reg  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_reg   <= sum_next[ACC_W-1:0];
                        ovf_reg   <= ovf_next;
                        count_reg <= count_next;
                        // The last product goes straight into the result
                        // registers. out_valid is then high on the next cycle.
                        if (count_next == target_reg) begin
                            out_sum_reg <= sum_next[ACC_W-1:0];
                            out_ovf_reg <= ovf_next;
                            state_reg   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == ACCUM) || (state_reg == DONE);
    assign out_sum   = out_sum_reg;
    assign out_ovf   = out_ovf_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Testbench for mult_product_accumulator.
//
// Two instances share every input. One is the default 16-bit accumulator and
// one is an 8-bit accumulator that can overflow. A behavioural model tracks
// the batch as a plain integer running total. Every cycle, just after the
// clock edge, it checks both instances. Directed sequences also pin the model
// with hand-computed literal values.
module tb_mult_product_accumulator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_prod;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
    logic [15:0] a_out_sum;
    logic [4:0]  a_count;
    logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic [7:0]  b_out_sum;
    logic [4:0]  b_count;

    int tests = 0;
    int fails = 0;

    mult_product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN_W(4)) u_acc16 (
        .clk(clk), .rst(rst), .start(start), .len(len), .clear(clear),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_prod(in_prod),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
        .out_ovf(a_out_ovf), .busy(a_busy), .count(a_count)
    );

    mult_product_accumulator #(.PROD_W(8), .ACC_W(8), .LEN_W(4)) u_acc8 (
        .clk(clk), .rst(rst), .start(start), .len(len), .clear(clear),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_prod(in_prod),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
        .out_ovf(b_out_ovf), .busy(b_busy), .count(b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 collecting products, 2 result waiting
    int m_mode, m_target, m_total, m_count, m_result;

    task automatic model_reset();
        m_mode = 0; m_target = 0; m_total = 0; m_count = 0; m_result = 0;
    endtask

    task automatic model_step();
        if (clear) begin
            m_mode = 0; m_total = 0; m_count = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_target = (len == 4'd0) ? 16 : int'(len);
                m_total = 0; m_count = 0; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (in_valid) begin
                m_total += int'(in_prod);
                m_count++;
                if (m_count == m_target) begin
                    m_result = m_total;
                    m_mode = 2;
                end
            end
        end else begin
            if (out_ready) m_mode = 0;
        end
    endtask

    // A carry out can only occur once the running total passes 2**W-1,
    // because the total only grows. The sticky flag is therefore total >= 2**W.
    always begin
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check("in_ready16",  32'(a_in_ready),  32'(m_mode == 1));
        check("out_valid16", 32'(a_out_valid), 32'(m_mode == 2));
        check("busy16",      32'(a_busy),      32'(m_mode != 0));
        check("count16",     32'(a_count),     32'(m_count));
        check("out_sum16",   32'(a_out_sum),   32'(m_result % 65536));
        check("out_ovf16",   32'(a_out_ovf),   32'(m_result > 65535));
        check("in_ready8",   32'(b_in_ready),  32'(m_mode == 1));
        check("out_valid8",  32'(b_out_valid), 32'(m_mode == 2));
        check("busy8",       32'(b_busy),      32'(m_mode != 0));
        check("count8",      32'(b_count),     32'(m_count));
        check("out_sum8",    32'(b_out_sum),   32'(m_result % 256));
        check("out_ovf8",    32'(b_out_ovf),   32'(m_result > 255));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_batch(input int l);
        start = 1'b1;
        len = 4'(l);
        tick();
        start = 1'b0;
    endtask

    // Holds in_valid with the product until an edge accepts it.
    task automatic feed(input int p);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_prod = 8'(p);
        for (int i = 0; i < 50 && !done; i++) begin
            if (a_in_ready) done = 1'b1;
            tick();
        end
        if (!done) check("feed_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handshake_valid_drop", 32'(a_out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 4'd0; clear = 1'b0;
        in_valid = 1'b0; in_prod = 8'd0; out_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_busy", 32'(a_busy), 32'd0);

        // len=4, back-to-back products
        start_batch(4);
        feed(6); feed(15); feed(64); feed(225);
        in_valid = 1'b0;
        check("b1_latency_valid", 32'(a_out_valid), 32'd1);
        check("b1_sum", 32'(a_out_sum), 32'd310);
        check("b1_ovf", 32'(a_out_ovf), 32'd0);
        check("b1_count", 32'(a_count), 32'd4);
        $display("[TB] batch len=4 sum=%0d ovf=%0d", a_out_sum, a_out_ovf);
        handshake();
        check("b1_idle", 32'(a_busy), 32'd0);

        // async reset mid-batch after three accepts
        start_batch(6);
        feed(10); feed(20); feed(30);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_sum", 32'(a_out_sum), 32'd0);
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        $display("[TB] async reset mid-batch sum=%0d count=%0d", a_out_sum, a_count);
        tick(); tick();
        rst = 1'b0;
        tick();

        // len=0 -> 16 products of 225 with random gaps
        start_batch(0);
        for (int i = 0; i < 16; i++) begin
            feed(225);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        check("b2_sum", 32'(a_out_sum), 32'd3600);
        check("b2_count", 32'(a_count), 32'd16);
        check("b2_in_ready_done", 32'(a_in_ready), 32'd0);
        check("b2_sum8", 32'(b_out_sum), 32'd16);
        check("b2_ovf8", 32'(b_out_ovf), 32'd1);
        $display("[TB] batch len=16 sum=%0d sum8=%0d", a_out_sum, b_out_sum);
        handshake();

        // backpressure
        start_batch(2);
        feed(9); feed(9);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(a_out_valid), 32'd1);
            check("bp_sum", 32'(a_out_sum), 32'd18);
            in_valid = 1'(i % 2);
            in_prod = 8'd99;
            tick();
        end
        $display("[TB] backpressure held sum=%0d", a_out_sum);
        handshake();

        // narrow accumulator overflow
        start_batch(2);
        feed(200); feed(100);
        in_valid = 1'b0;
        check("ovf_sum8", 32'(b_out_sum), 32'd44);
        check("ovf_flag8", 32'(b_out_ovf), 32'd1);
        check("ovf_sum16", 32'(a_out_sum), 32'd300);
        $display("[TB] acc8 batch sum=%0d ovf=%0d", b_out_sum, b_out_ovf);
        handshake();

        // clear in ACCUM, then clear in DONE, then a clean batch
        start_batch(5);
        feed(1); feed(2);
        in_valid = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_accum_ready", 32'(a_in_ready), 32'd0);
        check("clr_accum_count", 32'(a_count), 32'd0);
        start_batch(1);
        feed(3);
        in_valid = 1'b0;
        check("clr_done_pre", 32'(a_out_valid), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_done_valid", 32'(a_out_valid), 32'd0);
        check("clr_done_sum_kept", 32'(a_out_sum), 32'd3);
        start_batch(1);
        feed(7);
        in_valid = 1'b0;
        check("post_clear_sum", 32'(a_out_sum), 32'd7);
        $display("[TB] clear sequence, next batch sum=%0d", a_out_sum);
        handshake();

        // random traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            clear     = ($urandom_range(0, 40) == 0);
            start     = ($urandom_range(0, 3) == 0);
            len       = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 2) != 0);
            in_prod   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        clear = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
